toggle_hs_responder: RTL and testbench

//   Responder end of a two-phase (toggle) request/acknowledge handshake. The

---
 rtl/toggle_hs_responder.sv | 89 ++++++++
 tb/tb_toggle_hs_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_hs_responder.sv
// Responder end of a two-phase req/ack handshake: synchronises the request
// toggle, presents the payload on a valid/ready port, then toggles the ack.
module toggle_hs_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    input  logic              out_ready,
    input  logic              err_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              ack_tgl,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              proto_err
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   seen_q;
    logic                   valid_q;
    logic [DATA_W-1:0]      data_q;
    logic                   ack_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   err_q;
    logic                   req_s;
    logic                   new_req;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], req_tgl};
    assign req_s   = sync_q[SYNC_STAGES-1];
    assign new_req = (req_s != seen_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            seen_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            // A toggle still pending while holding means the initiator
            // did not wait for our ack; set has priority over clear.
            if (state_q == HOLD && new_req) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (new_req) begin
                        data_q  <= req_data;
                        seen_q  <= req_s;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= ~ack_q;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign ack_tgl   = ack_q;
    assign xfer_cnt  = cnt_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_toggle_hs_responder.sv
// Randomised transaction-level bench for toggle_hs_responder with a
// counting/parity reference model of completed transfers.
module tb_toggle_hs_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_tgl;
    logic [7:0] req_data;
    logic       out_ready;
    logic       err_clr;
    logic       out_valid;
    logic [7:0] out_data;
    logic       ack_tgl;
    logic [7:0] xfer_cnt;
    logic       proto_err;

    int errors = 0;
    int checks = 0;

    // Reference model: transfers completed since reset, error flag.
    int   done_n = 0;
    logic err_m  = 1'b0;

    toggle_hs_responder #(
        .DATA_W(8),
        .SYNC_STAGES(2),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_tgl(req_tgl),
        .req_data(req_data),
        .out_ready(out_ready),
        .err_clr(err_clr),
        .out_valid(out_valid),
        .out_data(out_data),
        .ack_tgl(ack_tgl),
        .xfer_cnt(xfer_cnt),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_m();
        return 32'(done_n % 256);
    endfunction

    function automatic logic [31:0] ack_m();
        return 32'(done_n % 2);
    endfunction

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic complete_chk(input string tag);
        done_n++;
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ack"}, 32'(ack_tgl), ack_m());
        check({tag, "_cnt"}, 32'(xfer_cnt), cnt_m());
        check({tag, "_err"}, 32'(proto_err), 32'(err_m));
    endtask

    // One well-behaved transfer; ready is random while idle (ignored there).
    task automatic xfer(input logic [7:0] d, input int stalls);
        req_data = d;
        req_tgl  = ~req_tgl;
        for (int i = 1; i <= 3; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            edge1();
            check("lat_valid", 32'(out_valid), (i == 3) ? 32'd1 : 32'd0);
        end
        check("cap_data", 32'(out_data), 32'(d));
        out_ready = 1'b0;
        for (int s = 0; s < stalls; s++) begin
            edge1();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'(d));
            check("bp_ack", 32'(ack_tgl), ack_m());
        end
        out_ready = 1'b1;
        edge1();
        complete_chk("done");
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_tgl   = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        done_n    = 0;
        err_m     = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ack", 32'(ack_tgl), 32'd0);
        check("rst_cnt", 32'(xfer_cnt), 32'd0);
        check("rst_err", 32'(proto_err), 32'd0);
        edge1();
        rst = 1'b0;
    endtask

    initial begin
        req_data = 8'h00;
        do_reset();

        // Basic transfer and backpressure
        xfer(8'hA5, 0);
        xfer(8'hA5, 5);

        // Back-to-back 01..04
        for (int k = 1; k <= 4; k++) xfer(8'(k), 0);
        check("b2b_ack", 32'(ack_tgl), 32'd0);

        for (int k = 0; k < 40; k++)
            xfer(8'($urandom), int'($urandom_range(0, 4)));

        // Violation: extra toggle while holding
        req_data = 8'h3C;
        req_tgl  = ~req_tgl;
        repeat (3) edge1();
        check("v_valid", 32'(out_valid), 32'd1);
        req_tgl = ~req_tgl;
        repeat (4) edge1();
        err_m = 1'b1;
        check("v_err", 32'(proto_err), 32'd1);
        check("v_hold", 32'(out_data), 32'h3C);
        out_ready = 1'b1;
        edge1();
        complete_chk("v_ack1");
        req_data  = 8'hC3;
        out_ready = 1'b0;
        edge1();
        check("v_pend_valid", 32'(out_valid), 32'd1);
        check("v_pend_data", 32'(out_data), 32'hC3);
        out_ready = 1'b1;
        edge1();
        complete_chk("v_ack2");
        out_ready = 1'b0;
        err_clr   = 1'b1;
        edge1();
        err_clr = 1'b0;
        err_m   = 1'b0;
        check("clr_err", 32'(proto_err), 32'd0);

        // Clear together with a fresh violation: set must win
        req_data = 8'h5A;
        req_tgl  = ~req_tgl;
        repeat (3) edge1();
        req_tgl = ~req_tgl;
        err_clr = 1'b1;
        repeat (4) edge1();
        err_m = 1'b1;
        check("clrset_err", 32'(proto_err), 32'd1);
        err_clr   = 1'b0;
        out_ready = 1'b1;
        edge1();
        complete_chk("cs_ack1");
        req_data = 8'h96;
        edge1();
        check("cs_pend_data", 32'(out_data), 32'h96);
        edge1();
        complete_chk("cs_ack2");
        out_ready = 1'b0;
        err_clr   = 1'b1;
        edge1();
        err_clr = 1'b0;
        err_m   = 1'b0;
        check("clr2_err", 32'(proto_err), 32'd0);

        // Counter wrap
        do_reset();
        for (int k = 0; k < 256; k++)
            xfer(8'($urandom), int'($urandom_range(0, 1)));
        check("wrap_cnt", 32'(xfer_cnt), 32'd0);
        check("wrap_ack", 32'(ack_tgl), 32'd0);
        check("wrap_err", 32'(proto_err), 32'd0);

        // Asynchronous reset during HOLD
        xfer(8'h11, 0);
        req_data = 8'h22;
        req_tgl  = ~req_tgl;
        repeat (3) edge1();
        check("r6_valid", 32'(out_valid), 32'd1);
        #3;
        rst     = 1'b1;
        req_tgl = 1'b0;
        #1;
        done_n = 0;
        check("r6_valid0", 32'(out_valid), 32'd0);
        check("r6_ack0", 32'(ack_tgl), 32'd0);
        check("r6_cnt0", 32'(xfer_cnt), 32'd0);
        check("r6_err0", 32'(proto_err), 32'd0);
        edge1();
        rst = 1'b0;
        edge1();
        check("r6_idle", 32'(out_valid), 32'd0);
        xfer(8'h77, 2);
        check("r6_cnt", 32'(xfer_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
